// File: rtl/hamming_result_checker.sv
// hamming_result_checker: scans a finished Hamming encode/decode program's memory and reports per-message pass/fail
// Ports:
//   clk_i           system clock
//   reset_i         synchronous reset, active-low
//   start_i         one-cycle pulse starting a check run (honoured only when idle)
//   mode_i          0 = check encode (program 1), 1 = check decode (program 2); latched on start
//   mem_rd_en_o     memory read strobe
//   mem_addr_o      memory byte address
//   mem_rd_data_i   read data, valid one cycle after the address is presented
//   busy_o          high from accepted start until done rises
//   done_o          high from run completion until the next start or reset
//   pass_o          valid while done_o; 1 when no message mismatched
//   err_count_o     number of mismatching messages
//   err_mask_o      bit i set when message i mismatched
//   first_err_o     lowest mismatching index, 4'hF when none
module hamming_result_checker #(
  parameter int NMSG   = 15,
  parameter int P1_IN  = 0,
  parameter int P1_OUT = 30,
  parameter int P2_IN  = 64,
  parameter int P2_OUT = 94
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        mode_i,
  output logic        mem_rd_en_o,
  output logic [7:0]  mem_addr_o,
  input  logic [7:0]  mem_rd_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [3:0]  err_count_o,
  output logic [14:0] err_mask_o,
  output logic [3:0]  first_err_o
);
  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, CMP, FIN} state_t;
  state_t      state_q;
  logic [3:0]  idx_q;
  logic        mode_q;
  logic [7:0]  in_lo_q, out_lo_q, out_hi_q;
  logic [6:0]  in_hi_q;
  logic        rd_en_q, busy_q, done_q, pass_q;
  logic [7:0]  addr_q;
  logic [3:0]  err_count_q, first_err_q;
  logic [14:0] err_mask_q;
  logic [11:1] d;
  logic [15:1] w;
  logic [3:0]  syn;
  logic [15:0] enc_w, dec_w, exp_w;
  logic        mismatch;
  // o selects the output region, hi selects the upper byte of the message
  function automatic logic [7:0] addr_f(input logic m, input logic o, input logic [3:0] i, input logic hi);
    return 8'((o ? (m ? P2_OUT : P1_OUT) : (m ? P2_IN : P1_IN)) + 2 * int'(i) + int'(hi));
  endfunction
  always_comb begin
    d = {in_hi_q[2:0], in_lo_q};
    w = {in_hi_q, in_lo_q};
    enc_w = {1'b0, d[11:5], ^d[11:5], d[4:2], (^d[11:8]) ^ (^d[4:2]), d[1],
             d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1],
             d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1]};
    syn = '0;
    for (int j = 1; j < 16; j++) syn = w[j] ? syn ^ 4'(j) : syn;
    dec_w = '0;
    // data bit k sits at codeword position k+3, skipping parity positions 4 and 8
    for (int k = 0; k < 11; k++) begin
      int p;
      p = k + 3 + int'(k > 0) + int'(k > 3);
      dec_w[k] = w[p] ^ (syn == 4'(p));
    end
    exp_w = mode_q ? dec_w : enc_w;
    mismatch = exp_w != {out_hi_q, out_lo_q};
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      in_lo_q     <= '0;
      in_hi_q     <= '0;
      out_lo_q    <= '0;
      out_hi_q    <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_mask_q  <= '0;
      first_err_q <= 4'hF;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          mode_q      <= mode_i;
          idx_q       <= '0;
          busy_q      <= 1'b1;
          done_q      <= 1'b0;
          pass_q      <= 1'b0;
          err_count_q <= '0;
          err_mask_q  <= '0;
          first_err_q <= 4'hF;
          addr_q      <= addr_f(mode_i, 1'b0, 4'd0, 1'b0);
          rd_en_q     <= 1'b1;
          state_q     <= RD0;
        end
        RD0: begin
          addr_q  <= addr_f(mode_q, 1'b0, idx_q, 1'b1);
          state_q <= RD1;
        end
        RD1: begin
          in_lo_q <= mem_rd_data_i;
          addr_q  <= addr_f(mode_q, 1'b1, idx_q, 1'b0);
          state_q <= RD2;
        end
        RD2: begin
          in_hi_q <= mem_rd_data_i[6:0];
          addr_q  <= addr_f(mode_q, 1'b1, idx_q, 1'b1);
          state_q <= RD3;
        end
        RD3: begin
          out_lo_q <= mem_rd_data_i;
          rd_en_q  <= 1'b0;
          state_q  <= CAP;
        end
        CAP: begin
          out_hi_q <= mem_rd_data_i;
          state_q  <= CMP;
        end
        CMP: begin
          if (mismatch) begin
            err_mask_q[idx_q] <= 1'b1;
            err_count_q       <= err_count_q + 4'd1;
            if (first_err_q == 4'hF) first_err_q <= idx_q;
          end
          if (idx_q == 4'(NMSG - 1)) state_q <= FIN;
          else begin
            idx_q   <= idx_q + 4'd1;
            addr_q  <= addr_f(mode_q, 1'b0, idx_q + 4'd1, 1'b0);
            rd_en_q <= 1'b1;
            state_q <= RD0;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= err_count_q == 4'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_rd_en_o = rd_en_q;
  assign mem_addr_o  = addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_count_q;
  assign err_mask_o  = err_mask_q;
  assign first_err_o = first_err_q;
endmodule
